ofdm_burst_streamer: RTL and testbench

//  Downstream stage of the time-synchronizer output buffer. When the buffer reports full, reads
//  the CP-stripped burst (4 channel-est + 8 data symbols, 64 samples each = 768 samples) through
//  the buffer's read_ptr/dout port. Streams it to the FFT as AXI-Stream with per-symbol framing,

---
 rtl/ofdm_burst_streamer_if.sv | 28 ++
 rtl/ofdm_burst_streamer.sv | 159 +++++++++++++++
 tb/tb_ofdm_burst_streamer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_burst_streamer_if.sv
// AXI-Stream bundle between the burst streamer and the FFT.
`timescale 1ns/1ps

interface ofdm_burst_streamer_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [3:0]    m_axis_tuser;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        output m_axis_tuser,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        input  m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/ofdm_burst_streamer.sv
// Reads one CP-stripped burst out of the synchronizer output buffer and
// streams it to the FFT with per-symbol tlast/tuser framing.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for buff_full
// S_STREAM   | issuing buffer reads and emitting beats until beat 767
// S_RELEASE  | tx_done high for one cycle
// S_WAIT_CLR | waiting for buff_full to drop before re-arming
//
// Reads are credit limited: a read is only issued if the skid FIFO (memory
// plus output register) can absorb it together with every read still in the
// RD_LAT pipe, so in-flight samples never need to be stalled.
`timescale 1ns/1ps

module ofdm_burst_streamer #(
    parameter int FFT_POINT  = 64,
    parameter int NUM_SYM    = 12,
    parameter int DW         = 8,
    parameter int AW         = 10,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          buff_full,
    output logic [AW-1:0] read_ptr,
    input  logic [DW-1:0] din,
    output logic          tx_done,
    output logic          busy,
    ofdm_burst_streamer_if.master axis
);

    localparam int BURST = FFT_POINT * NUM_SYM;
    localparam int SW    = $clog2(FFT_POINT);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_STREAM   = 2'd1;
    localparam logic [1:0] S_RELEASE  = 2'd2;
    localparam logic [1:0] S_WAIT_CLR = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] rd_cnt_q;
    logic [AW-1:0] read_ptr_q;
    logic [AW-1:0] beat_cnt_q;
    logic [RD_LAT-1:0] vld_q;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          out_vld_q;
    logic [DW-1:0] out_data_q;

    int   occupancy;
    logic issue, push, pop, load_out, last_hs;

    // Occupancy seen by the credit check: FIFO memory, output register and reads in flight.
    always_comb begin
        occupancy = int'(cnt_q) + int'(out_vld_q);
        for (int i = 0; i < RD_LAT; i++) begin
            occupancy = occupancy + int'(vld_q[i]);
        end
    end

    assign issue    = (state_q == S_STREAM) && (int'(rd_cnt_q) < BURST)
                      && (occupancy < FIFO_DEPTH);
    assign push     = vld_q[RD_LAT-1];
    assign pop      = out_vld_q && axis.m_axis_tready;
    assign load_out = (cnt_q != '0) && (!out_vld_q || axis.m_axis_tready);
    assign last_hs  = pop && (beat_cnt_q == AW'(BURST - 1));

    // Burst sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (buff_full) state_d = S_STREAM;
            S_STREAM:   if (last_hs)   state_d = S_RELEASE;
            S_RELEASE:  state_d = S_WAIT_CLR;
            S_WAIT_CLR: if (!buff_full) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State register, read address generation and the in-flight valid pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= '0;
            read_ptr_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q  <= state_d;
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (issue) begin
                read_ptr_q <= rd_cnt_q;
                rd_cnt_q   <= rd_cnt_q + AW'(1);
            end else if (state_q == S_RELEASE) begin
                rd_cnt_q <= '0;
            end
        end
    end

    // Sample storage; contents need no reset because cnt_q guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // FIFO pointers, fill count and the registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (load_out) begin
                rd_ptr_q   <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
                out_vld_q  <= 1'b1;
                out_data_q <= mem[rd_ptr_q];
            end else if (pop) begin
                out_vld_q <= 1'b0;
            end
            case ({push, load_out})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Beat counter; framing is derived from it so it stays put during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else if (pop) begin
            beat_cnt_q <= last_hs ? '0 : beat_cnt_q + AW'(1);
        end
    end

    assign read_ptr           = read_ptr_q;
    assign tx_done            = (state_q == S_RELEASE);
    assign busy               = (state_q != S_IDLE);
    assign axis.m_axis_tdata  = out_data_q;
    assign axis.m_axis_tvalid = out_vld_q;
    assign axis.m_axis_tlast  = (beat_cnt_q[SW-1:0] == SW'(FFT_POINT - 1));
    assign axis.m_axis_tuser  = 4'(beat_cnt_q >> SW);

endmodule

// File: tb/tb_ofdm_burst_streamer.sv
// Bench for ofdm_burst_streamer: upstream buffer model returning addr[7:0],
// a beat-index reference model for the AXI-S stream, and directed sequences
// for latency, back-pressure, reset and re-arm behaviour.
`timescale 1ns/1ps

module tb_ofdm_burst_streamer;

    localparam int BURST = 768;
    localparam int RD_LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       buff_full;
    logic [9:0] read_ptr;
    logic [7:0] din;
    logic       tx_done;
    logic       busy;

    ofdm_burst_streamer_if #(.DW(8)) axis_if ();

    ofdm_burst_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .buff_full (buff_full),
        .read_ptr  (read_ptr),
        .din       (din),
        .tx_done   (tx_done),
        .busy      (busy),
        .axis      (axis_if)
    );

    always #5 clk = ~clk;

    // Upstream buffer: read_ptr register plus two more stages = RD_LAT.
    logic [9:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= read_ptr;
        p2 <= p1;
    end
    assign din = p2[7:0];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // tready pattern: 0 = always high, 1 = random 30% high, 2 = held low
    int tr_mode = 0;
    initial begin
        axis_if.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       axis_if.m_axis_tready = 1'b1;
                1:       axis_if.m_axis_tready = ($urandom_range(0, 99) < 30);
                default: axis_if.m_axis_tready = 1'b0;
            endcase
        end
    end

    // Reference model: beat k of a burst carries sample k mod 256,
    // tlast when k mod 64 == 63, tuser = k / 64; tx_done the cycle after beat 767.
    int         exp_idx = 0;
    int         beats_total = 0;
    int         tlast_cnt = 0;
    int         done_cnt = 0;
    bit         pend_done = 0;
    bit         prev_stall = 0;
    logic [7:0] pv_data;
    logic       pv_last;
    logic [3:0] pv_user;

    always @(negedge clk) begin
        if (rst) begin
            exp_idx    = 0;
            pend_done  = 0;
            prev_stall = 0;
        end else begin
            if (pend_done) begin
                chk("tx_done_after_last_beat", int'(tx_done), 1);
                pend_done = 0;
            end else if (tx_done) begin
                chk("tx_done_spurious", 1, 0);
            end
            if (tx_done) done_cnt++;
            if (prev_stall) begin
                chk("stall_tvalid", int'(axis_if.m_axis_tvalid), 1);
                chk("stall_tdata", int'(axis_if.m_axis_tdata), int'(pv_data));
                chk("stall_tlast", int'(axis_if.m_axis_tlast), int'(pv_last));
                chk("stall_tuser", int'(axis_if.m_axis_tuser), int'(pv_user));
            end
            if (axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
                chk("beat_tdata", int'(axis_if.m_axis_tdata), exp_idx % 256);
                chk("beat_tlast", int'(axis_if.m_axis_tlast), int'((exp_idx % 64) == 63));
                chk("beat_tuser", int'(axis_if.m_axis_tuser), exp_idx / 64);
                if (axis_if.m_axis_tlast) tlast_cnt++;
                beats_total++;
                exp_idx++;
                if (exp_idx == BURST) begin
                    exp_idx   = 0;
                    pend_done = 1;
                end
            end
            prev_stall = axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
            pv_data = axis_if.m_axis_tdata;
            pv_last = axis_if.m_axis_tlast;
            pv_user = axis_if.m_axis_tuser;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!tx_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!tx_done) chk({name, "_timeout"}, 0, 1);
    endtask

    // Waits for tx_done, then checks the burst delivered exactly 768 beats.
    task automatic end_burst(input string name, input int budget, input int b0, input int l0, input int d0);
        wait_done(budget, name);
        #1;
        chk({name, "_beats"}, beats_total - b0, BURST);
        chk({name, "_tlasts"}, tlast_cnt - l0, 12);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_read_ptr"}, int'(read_ptr), 0);
        chk({name, "_tvalid"}, int'(axis_if.m_axis_tvalid), 0);
        chk({name, "_tdata"}, int'(axis_if.m_axis_tdata), 0);
        chk({name, "_tlast"}, int'(axis_if.m_axis_tlast), 0);
        chk({name, "_tuser"}, int'(axis_if.m_axis_tuser), 0);
        chk({name, "_tx_done"}, int'(tx_done), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    typedef struct {
        int rp;
        int tv;
        int td;
        int bz;
    } lat_vec_t;

    lat_vec_t lat_tab[8];

    initial begin
        int b0, l0, d0, n;

        // After sampling edge k: read_ptr, tvalid, tdata, busy with tready=1.
        lat_tab[0] = '{0, 0, 0, 1};
        lat_tab[1] = '{0, 0, 0, 1};
        lat_tab[2] = '{1, 0, 0, 1};
        lat_tab[3] = '{2, 0, 0, 1};
        lat_tab[4] = '{3, 0, 0, 1};
        lat_tab[5] = '{4, 1, 0, 1};
        lat_tab[6] = '{5, 1, 1, 1};
        lat_tab[7] = '{6, 1, 2, 1};

        rst = 1'b1;
        buff_full = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // 1: continuous tready, latency table then full burst
        tr_mode = 0;
        b0 = beats_total; l0 = tlast_cnt; d0 = done_cnt;
        buff_full = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("lat%0d_read_ptr", k), int'(read_ptr), lat_tab[k].rp);
            chk($sformatf("lat%0d_tvalid", k), int'(axis_if.m_axis_tvalid), lat_tab[k].tv);
            chk($sformatf("lat%0d_tdata", k), int'(axis_if.m_axis_tdata), lat_tab[k].td);
            chk($sformatf("lat%0d_busy", k), int'(busy), lat_tab[k].bz);
        end
        end_burst("t1", 3000, b0, l0, d0);
        buff_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", int'(busy), 0);

        // 2: random 30% tready, three bursts
        tr_mode = 1;
        for (int b = 0; b < 3; b++) begin
            b0 = beats_total; l0 = tlast_cnt; d0 = done_cnt;
            buff_full = 1'b1;
            end_burst($sformatf("t2_b%0d", b), 8000, b0, l0, d0);
            buff_full = 1'b0;
            repeat ($urandom_range(2, 6)) @(negedge clk);
        end

        // 3: tready held low from burst start
        tr_mode = 2;
        repeat (2) @(negedge clk);
        b0 = beats_total; l0 = tlast_cnt; d0 = done_cnt;
        buff_full = 1'b1;
        repeat (100) @(negedge clk);
        chk("t3_read_ptr_stop", int'(read_ptr), 7);
        chk("t3_tvalid", int'(axis_if.m_axis_tvalid), 1);
        chk("t3_tdata", int'(axis_if.m_axis_tdata), 0);
        chk("t3_no_beats", beats_total - b0, 0);
        tr_mode = 0;
        end_burst("t3", 3000, b0, l0, d0);
        buff_full = 1'b0;
        repeat (3) @(negedge clk);

        // 4: reset after beat 300, then a fresh burst with buff_full held
        b0 = beats_total;
        buff_full = 1'b1;
        n = 0;
        while ((beats_total - b0) <= 300 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_beat300", int'((beats_total - b0) > 300), 1);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t4_mid_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t4_no_done_on_reset", done_cnt - d0, 0);
        b0 = beats_total; l0 = tlast_cnt; d0 = done_cnt;
        end_burst("t4_restart", 3000, b0, l0, d0);

        // 5: buff_full held 20 cycles after tx_done, no new reads
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_read_ptr_hold", int'(read_ptr), 767);
            chk("t5_tvalid_low", int'(axis_if.m_axis_tvalid), 0);
            chk("t5_busy", int'(busy), 1);
        end
        buff_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_rearm_idle", int'(busy), 0);

        // 6: back-to-back bursts with a one-cycle low between them
        b0 = beats_total; l0 = tlast_cnt; d0 = done_cnt;
        buff_full = 1'b1;
        wait_done(3000, "t6_first");
        buff_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        buff_full = 1'b1;
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            if (axis_if.m_axis_tvalid || n >= 20) break;
            @(posedge clk);
            n++;
        end
        chk("t6_first_tvalid_latency", n, RD_LAT + 2);
        wait_done(3000, "t6_second");
        #1;
        chk("t6_total_beats", beats_total - b0, 2 * BURST);
        chk("t6_total_tlasts", tlast_cnt - l0, 24);
        chk("t6_done_pulses", done_cnt - d0, 2);
        buff_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_final_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
